// File: rtl/core_pkg.sv
// Shared core definitions: register addressing and hazard-cause codes.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_WAW,
    HZ_CAP
  } hz_cause_e;

endpackage

// File: rtl/hazard_scoreboard_reg_bit.sv
// One pending flop; a set in the same cycle as a clear wins.
module sb_reg_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Long-latency destination scoreboard: stalls ID on RAW/WAW/capacity
// hazards and retires entries from the write-back port.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_long,
  input  logic                  flush,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic                  issue_fire,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  full,
  output logic                  spurious_wb
);

  logic [NUM_REGS-1:0] w_pend;
  logic [NUM_REGS-1:0] w_wb_dec;
  logic [NUM_REGS-1:0] w_eff;
  logic                w_raw;
  logic                w_waw;
  logic                w_cap;
  logic                w_wb_pend;
  logic                w_clear;
  logic                w_set;
  logic                w_spur;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_full;
  logic                r_spur;

  always_comb begin
    w_wb_dec = '0;
    if (wb_valid) begin
      w_wb_dec[wb_rd] = 1'b1;
    end
  end

  // A retiring register is forwarded, so it no longer blocks issue.
  assign w_eff = w_pend & ~w_wb_dec;

  assign w_raw = (id_use_rs1 & (id_rs1 != X0) & w_eff[id_rs1])
               | (id_use_rs2 & (id_rs2 != X0) & w_eff[id_rs2]);
  assign w_waw = (id_rd != X0) & w_eff[id_rd];

  assign w_wb_pend = wb_valid & w_pend[wb_rd];
  assign w_cap = id_long & (id_rd != X0) & r_full & ~w_wb_pend;

  assign stall      = id_valid & ~flush & (w_raw | w_waw | w_cap);
  assign issue_fire = id_valid & ~stall & ~flush;

  assign w_clear = w_wb_pend & (wb_rd != X0);
  assign w_set   = issue_fire & id_long & (id_rd != X0);
  assign w_spur  = wb_valid & ~w_clear;

  assign w_pend[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_bit
    sb_reg_bit u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .i_set (w_set & (id_rd == REG_ADDR_W'(g))),
      .i_clr (w_clear & (wb_rd == REG_ADDR_W'(g))),
      .o_q   (w_pend[g])
    );
  end

  assign w_cnt_nxt = r_cnt - CNT_W'(w_clear) + CNT_W'(w_set);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_spur <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == CNT_W'(MAX_OUTSTANDING));
      r_spur <= r_spur | w_spur;
    end
  end

  assign pending_mask = w_pend;
  assign outstanding  = r_cnt;
  assign full         = r_full;
  assign spurious_wb  = r_spur;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_long;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic        issue_fire;
  logic [31:0] pending_mask;
  logic [2:0]  outstanding;
  logic        full;
  logic        spurious_wb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_long      (id_long),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .stall        (stall),
    .issue_fire   (issue_fire),
    .pending_mask (pending_mask),
    .outstanding  (outstanding),
    .full         (full),
    .spurious_wb  (spurious_wb)
  );

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0h required=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    id_valid   = 1'b0;
    id_rs1     = '0;
    id_rs2     = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    id_rd      = '0;
    id_long    = 1'b0;
    flush      = 1'b0;
    wb_valid   = 1'b0;
    wb_rd      = '0;
  endtask

  task automatic long_op(input logic [4:0] rd);
    id_valid   = 1'b1;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    id_rd      = rd;
    id_long    = 1'b1;
  endtask

  task automatic add_rs1(input logic [4:0] rs, input logic [4:0] rd);
    id_valid   = 1'b1;
    id_use_rs1 = 1'b1;
    id_rs1     = rs;
    id_use_rs2 = 1'b0;
    id_rd      = rd;
    id_long    = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid = 1'b1;
    wb_rd    = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string t, input logic [31:0] m,
                           input logic [2:0] c);
    expect_v({t, "_mask"}, 64'(m));
    chk(64'(pending_mask));
    expect_v({t, "_cnt"}, 64'(c));
    chk(64'(outstanding));
  endtask

  task automatic chk_issue(input string t, input logic s, input logic f);
    #1;
    expect_v({t, "_stall"}, 64'(s));
    chk(64'(stall));
    expect_v({t, "_fire"}, 64'(f));
    chk(64'(issue_fire));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk_state("rst", 32'h0, 3'd0);
    expect_v("rst_full", 0); chk(64'(full));
    expect_v("rst_spur", 0); chk(64'(spurious_wb));
    expect_v("rst_stall", 0); chk(64'(stall));
    @(negedge clk);
    rst_n = 1'b1;

    // load x5, then dependent add stalls
    long_op(5'd5);
    chk_issue("ld5", 1'b0, 1'b1);
    tick();
    chk_state("ld5", 32'h20, 3'd1);
    add_rs1(5'd5, 5'd10);
    chk_issue("raw5", 1'b1, 1'b0);
    tick();
    chk_state("raw5_hold", 32'h20, 3'd1);

    // retire bypass releases the add
    retire(5'd5);
    chk_issue("byp5", 1'b0, 1'b1);
    tick();
    idle();
    chk_state("byp5", 32'h0, 3'd0);

    // fill to capacity
    for (int i = 1; i <= 4; i++) begin
      long_op(5'(i));
      tick();
    end
    idle();
    #1;
    chk_state("fill", 32'h1E, 3'd4);
    expect_v("fill_full", 1); chk(64'(full));
    long_op(5'd6);
    chk_issue("cap6", 1'b1, 1'b0);
    retire(5'd1);
    chk_issue("cap6_wb", 1'b0, 1'b1);
    tick();
    idle();
    chk_state("cap6", 32'h5C, 3'd4);
    expect_v("cap6_full", 1); chk(64'(full));

    // drain
    retire(5'd2); tick();
    retire(5'd3); tick();
    retire(5'd4); tick();
    retire(5'd6); tick();
    idle();
    chk_state("drain", 32'h0, 3'd0);
    expect_v("drain_full", 0); chk(64'(full));
    expect_v("drain_spur", 0); chk(64'(spurious_wb));

    // WAW on x7 and same-cycle clear+set
    long_op(5'd7);
    tick();
    chk_state("ld7", 32'h80, 3'd1);
    chk_issue("waw7", 1'b1, 1'b0);
    retire(5'd7);
    chk_issue("waw7_wb", 1'b0, 1'b1);
    tick();
    idle();
    chk_state("waw7", 32'h80, 3'd1);
    retire(5'd7);
    tick();
    idle();
    chk_state("ret7", 32'h0, 3'd0);

    // spurious retire and rd=0 long op
    retire(5'd9);
    tick();
    idle();
    expect_v("spur9", 1); chk(64'(spurious_wb));
    chk_state("spur9", 32'h0, 3'd0);
    tick();
    expect_v("spur9_sticky", 1); chk(64'(spurious_wb));
    long_op(5'd0);
    chk_issue("rd0", 1'b0, 1'b1);
    tick();
    idle();
    chk_state("rd0", 32'h0, 3'd0);

    // flush over a RAW stall, then async reset
    long_op(5'd3);
    tick();
    chk_state("ld3", 32'h08, 3'd1);
    add_rs1(5'd3, 5'd11);
    chk_issue("raw3", 1'b1, 1'b0);
    flush = 1'b1;
    chk_issue("flush3", 1'b0, 1'b0);
    tick();
    idle();
    chk_state("flush3", 32'h08, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("arst", 32'h0, 3'd0);
    expect_v("arst_spur", 0); chk(64'(spurious_wb));
    @(negedge clk);
    rst_n = 1'b1;
    retire(5'd3);
    tick();
    idle();
    expect_v("late_wb_spur", 1); chk(64'(spurious_wb));
    chk_state("late_wb", 32'h0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
